// File: rtl/cfg_uart.sv
// ---------------------------------------------------------------------------
// cfg_uart
//   Configuration UART. Assembles three received bytes into a 24-bit command
//   word, and sends a 16-bit response word back as two bytes (high byte
//   first). The receiver and transmitter run independently (full duplex).
//
//   Parameters
//     BAUD_DIV  clock cycles per UART bit (minimum 8)
//     GAP_BITS  idle bit times allowed between bytes of one command frame
//
//   Ports
//     clk       single clock, rising edge
//     rst       asynchronous, active-high reset
//     RX_C      serial command line in (8N1, idle high)
//     TX_C      serial response line out (8N1, idle high)
//     cmd       last complete 24-bit command (first byte in [23:16])
//     cmd_rdy   one-cycle pulse when cmd is updated
//     resp      response word to transmit
//     snd_rsp   request to transmit resp
//     rsp_busy  high while a response is being transmitted
//     rsp_done  one-cycle pulse when a response transmission finishes
//     frm_err   one-cycle pulse when a bad stop bit is sampled
// ---------------------------------------------------------------------------
module cfg_uart #(
  parameter int BAUD_DIV = 2604,
  parameter int GAP_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX_C,
  output logic        TX_C,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic [15:0] resp,
  input  logic        snd_rsp,
  output logic        rsp_busy,
  output logic        rsp_done,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  localparam int GAP_CYC = GAP_BITS * BAUD_DIV;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Receive side
  logic          rx_s1;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [23:0]   asm_reg;
  logic [1:0]    byte_cnt;
  logic [GW-1:0] gap_cnt;

  // Transmit side
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [2:0]    tx_bit_nxt;
  logic          byte_sel;
  logic [15:0]   tx_word;
  logic [7:0]    tx_byte;

  // Two-flop synchronizer on RX_C, plus one more flop holding the previous
  // synchronized value so the receiver can spot a falling edge. All three
  // reset to the idle (high) line level so reset release never looks like
  // a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX_C;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
    end
  end

  // Receiver FSM, byte assembly and inter-byte gap timer. The start bit is
  // re-checked at its middle, after which every sample lands mid-bit. A
  // partial frame is dropped if the line stays idle too long between bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      asm_reg  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      cmd_rdy <= 1'b0;
      frm_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            gap_cnt  <= '0;
          end else if (byte_cnt != 2'd0) begin
            if (gap_cnt == GAP_LAST) begin
              byte_cnt <= '0;
              gap_cnt  <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end else begin
            gap_cnt <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            // A line already back high at mid start bit was only a glitch
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              asm_reg <= {asm_reg[15:0], rx_shift};
              if (byte_cnt == 2'd2) begin
                cmd      <= {asm_reg[15:0], rx_shift};
                cmd_rdy  <= 1'b1;
                byte_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else begin
              frm_err  <= 1'b1;
              byte_cnt <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Byte currently on the wire: high byte first, then low byte
  always_comb begin
    tx_byte    = byte_sel ? tx_word[7:0] : tx_word[15:8];
    tx_bit_nxt = tx_bit + 3'd1;
  end

  // Transmitter FSM. TX_C is registered and its next level is chosen at the
  // last cycle of the current bit, so every bit lasts exactly BAUD_DIV
  // cycles and the second start bit follows the first stop bit directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      byte_sel <= 1'b0;
      tx_word  <= '0;
      TX_C     <= 1'b1;
      rsp_busy <= 1'b0;
      rsp_done <= 1'b0;
    end else begin
      rsp_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          byte_sel <= 1'b0;
          TX_C     <= 1'b1;
          if (snd_rsp) begin
            tx_word  <= resp;
            rsp_busy <= 1'b1;
            TX_C     <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            TX_C     <= tx_byte[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              TX_C     <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit_nxt;
              TX_C   <= tx_byte[tx_bit_nxt];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              TX_C     <= 1'b0;
              tx_state <= TX_START;
            end else begin
              byte_sel <= 1'b0;
              rsp_busy <= 1'b0;
              rsp_done <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_uart.sv
// ---------------------------------------------------------------------------
// tb_cfg_uart
//   Directed testbench for cfg_uart with BAUD_DIV=16, GAP_BITS=32.
//   Scenario tasks drive RX_C / snd_rsp and compare DUT outputs against
//   hand-computed values.
// ---------------------------------------------------------------------------
module tb_cfg_uart;

  localparam int BD = 16;
  localparam int GB = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX_C = 1'b1;
  logic        TX_C;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic [15:0] resp = 16'h0000;
  logic        snd_rsp = 1'b0;
  logic        rsp_busy;
  logic        rsp_done;
  logic        frm_err;

  int total = 0;
  int bad   = 0;

  int cyc      = 0;
  int rdy_cnt  = 0;
  int rdy_cyc  = 0;
  int frm_cnt  = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  cfg_uart #(.BAUD_DIV(BD), .GAP_BITS(GB)) dut (
    .clk      (clk),
    .rst      (rst),
    .RX_C     (RX_C),
    .TX_C     (TX_C),
    .cmd      (cmd),
    .cmd_rdy  (cmd_rdy),
    .resp     (resp),
    .snd_rsp  (snd_rsp),
    .rsp_busy (rsp_busy),
    .rsp_done (rsp_done),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;

  // Cycle counter, advanced on every rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse / level observers sampled on the falling edge, away from updates
  always @(negedge clk) begin
    if (cmd_rdy) begin
      rdy_cnt++;
      rdy_cyc = cyc;
    end
    if (frm_err)  frm_cnt++;
    if (rsp_done) done_cnt++;
    if (rsp_busy) busy_cnt++;
  end

  // Drive one 8N1 byte on RX_C; t0 is the cycle count when the start bit
  // began. A few idle-high cycles follow the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
    @(posedge clk); #1;
    t0 = cyc;
    RX_C = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(posedge clk); #1;
      RX_C = b[i];
    end
    repeat (BD) @(posedge clk); #1;
    RX_C = stop;
    repeat (BD) @(posedge clk); #1;
    RX_C = 1'b1;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [23:0] c);
    int t;
    send_byte(c[23:16], 1'b1, t);
    send_byte(c[15:8],  1'b1, t);
    send_byte(c[7:0],   1'b1, t);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++;
    if (TX_C !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b expected 1", TX_C); end
    total++;
    if (cmd !== 24'h0) begin bad++; $display("[TB] FAIL reset_cmd: got %h expected 000000", cmd); end
    total++;
    if (cmd_rdy !== 1'b0) begin bad++; $display("[TB] FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
    total++;
    if (rsp_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", rsp_busy); end
    total++;
    if (rsp_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", rsp_done); end
    total++;
    if (frm_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frm_err: got %b expected 0", frm_err); end
    rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    total++;
    if (cmd_rdy !== 1'b0 || TX_C !== 1'b1) begin
      bad++; $display("[TB] FAIL post_reset_idle: got rdy=%b tx=%b expected rdy=0 tx=1", cmd_rdy, TX_C);
    end
  endtask

  task automatic test_cmd_frame;
    int r0, f0, t;
    r0 = rdy_cnt;
    f0 = frm_cnt;
    send_byte(8'h3A, 1'b1, t);
    send_byte(8'h12, 1'b1, t);
    send_byte(8'h34, 1'b1, t);
    total++;
    if (cmd !== 24'h3A1234) begin bad++; $display("[TB] FAIL cmd_value: got %h expected 3a1234", cmd); end
    total++;
    if (rdy_cnt - r0 !== 1) begin bad++; $display("[TB] FAIL cmd_rdy_count: got %0d expected 1", rdy_cnt - r0); end
    // Start at t: 2 sync + 1 edge flop, +8 to mid start, +8*16 data, +16 stop
    total++;
    if (rdy_cyc - t !== 155) begin bad++; $display("[TB] FAIL cmd_rdy_timing: got %0d expected 155", rdy_cyc - t); end
    total++;
    if (frm_cnt - f0 !== 0) begin bad++; $display("[TB] FAIL cmd_frm_err: got %0d expected 0", frm_cnt - f0); end
  endtask

  // Send a response and check every bit mid-bit. Partway through, resp is
  // changed and snd_rsp is held high; neither may affect the transfer.
  task automatic test_tx(input logic [15:0] val);
    logic [19:0] exp;
    int d0, b0;
    exp = {1'b1, val[7:0], 1'b0, 1'b1, val[15:8], 1'b0};
    d0 = done_cnt;
    b0 = busy_cnt;
    @(posedge clk); #1;
    resp = val;
    snd_rsp = 1'b1;
    @(posedge clk); #1;
    snd_rsp = 1'b0;
    total++;
    if (rsp_busy !== 1'b1) begin bad++; $display("[TB] FAIL tx_busy_rise: got %b expected 1", rsp_busy); end
    repeat (7) @(posedge clk); #1;
    for (int j = 0; j < 20; j++) begin
      total++;
      if (TX_C !== exp[j]) begin
        bad++; $display("[TB] FAIL tx_bit%0d: got %b expected %b", j, TX_C, exp[j]);
      end
      if (j == 5) begin
        resp = ~val;
        snd_rsp = 1'b1;
      end
      repeat (BD) @(posedge clk); #1;
      snd_rsp = 1'b0;
    end
    repeat (20) @(posedge clk); #1;
    total++;
    if (busy_cnt - b0 !== 320) begin bad++; $display("[TB] FAIL tx_busy_cycles: got %0d expected 320", busy_cnt - b0); end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("[TB] FAIL tx_done_count: got %0d expected 1", done_cnt - d0); end
    total++;
    if (rsp_busy !== 1'b0 || TX_C !== 1'b1) begin
      bad++; $display("[TB] FAIL tx_idle_after: got busy=%b tx=%b expected busy=0 tx=1", rsp_busy, TX_C);
    end
  endtask

  task automatic test_frame_err;
    int r0, f0, t;
    r0 = rdy_cnt;
    f0 = frm_cnt;
    send_byte(8'h11, 1'b1, t);
    send_byte(8'h22, 1'b0, t);
    repeat (8) @(posedge clk); #1;
    total++;
    if (frm_cnt - f0 !== 1) begin bad++; $display("[TB] FAIL ferr_pulse: got %0d expected 1", frm_cnt - f0); end
    total++;
    if (rdy_cnt - r0 !== 0) begin bad++; $display("[TB] FAIL ferr_no_rdy: got %0d expected 0", rdy_cnt - r0); end
    total++;
    if (cmd !== 24'h3A1234) begin bad++; $display("[TB] FAIL ferr_cmd_hold: got %h expected 3a1234", cmd); end
    send_cmd(24'h0035A6);
    total++;
    if (cmd !== 24'h0035A6) begin bad++; $display("[TB] FAIL ferr_recover_cmd: got %h expected 0035a6", cmd); end
    total++;
    if (rdy_cnt - r0 !== 1) begin bad++; $display("[TB] FAIL ferr_recover_rdy: got %0d expected 1", rdy_cnt - r0); end
  endtask

  task automatic test_gap;
    int r0, t;
    r0 = rdy_cnt;
    send_byte(8'hFF, 1'b1, t);
    repeat (600) @(posedge clk); #1;
    total++;
    if (rdy_cnt - r0 !== 0) begin bad++; $display("[TB] FAIL gap_no_rdy: got %0d expected 0", rdy_cnt - r0); end
    send_cmd(24'h010203);
    total++;
    if (cmd !== 24'h010203) begin bad++; $display("[TB] FAIL gap_cmd: got %h expected 010203", cmd); end
    total++;
    if (rdy_cnt - r0 !== 1) begin bad++; $display("[TB] FAIL gap_rdy_count: got %0d expected 1", rdy_cnt - r0); end
  endtask

  // A 4-cycle low pulse between the first and second bytes must not count
  // as a byte; the frame still completes with the next two real bytes.
  task automatic test_glitch;
    int r0, f0, t;
    r0 = rdy_cnt;
    f0 = frm_cnt;
    send_byte(8'h55, 1'b1, t);
    repeat (20) @(posedge clk); #1;
    RX_C = 1'b0;
    repeat (4) @(posedge clk); #1;
    RX_C = 1'b1;
    repeat (100) @(posedge clk); #1;
    send_byte(8'h66, 1'b1, t);
    send_byte(8'h77, 1'b1, t);
    total++;
    if (cmd !== 24'h556677) begin bad++; $display("[TB] FAIL glitch_cmd: got %h expected 556677", cmd); end
    total++;
    if (rdy_cnt - r0 !== 1) begin bad++; $display("[TB] FAIL glitch_rdy: got %0d expected 1", rdy_cnt - r0); end
    total++;
    if (frm_cnt - f0 !== 0) begin bad++; $display("[TB] FAIL glitch_frm_err: got %0d expected 0", frm_cnt - f0); end
  endtask

  task automatic test_reset_mid_tx;
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    resp = 16'h0A5A;
    snd_rsp = 1'b1;
    @(posedge clk); #1;
    snd_rsp = 1'b0;
    // 99 cycles after the start bit began: frame bit 6 = bit 5 of 0x0A = 0
    repeat (99) @(posedge clk); #1;
    total++;
    if (TX_C !== 1'b0) begin bad++; $display("[TB] FAIL rsttx_before: got %b expected 0", TX_C); end
    rst = 1'b1;
    #1;
    total++;
    if (TX_C !== 1'b1) begin bad++; $display("[TB] FAIL rsttx_line: got %b expected 1", TX_C); end
    total++;
    if (rsp_busy !== 1'b0) begin bad++; $display("[TB] FAIL rsttx_busy: got %b expected 0", rsp_busy); end
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (400) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 !== 0) begin bad++; $display("[TB] FAIL rsttx_no_done: got %0d expected 0", done_cnt - d0); end
    total++;
    if (rsp_busy !== 1'b0 || TX_C !== 1'b1) begin
      bad++; $display("[TB] FAIL rsttx_no_resume: got busy=%b tx=%b expected busy=0 tx=1", rsp_busy, TX_C);
    end
  endtask

  task automatic test_full_duplex;
    int r0;
    r0 = rdy_cnt;
    fork
      test_tx(16'hC381);
      send_cmd(24'h5AA5C3);
    join
    total++;
    if (cmd !== 24'h5AA5C3) begin bad++; $display("[TB] FAIL duplex_cmd: got %h expected 5aa5c3", cmd); end
    total++;
    if (rdy_cnt - r0 !== 1) begin bad++; $display("[TB] FAIL duplex_rdy: got %0d expected 1", rdy_cnt - r0); end
  endtask

  initial begin
    $display("[TB] starting cfg_uart directed tests");
    test_reset();
    test_cmd_frame();
    test_tx(16'h0A5A);
    test_frame_err();
    test_gap();
    test_glitch();
    test_reset_mid_tx();
    test_full_duplex();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
